// File: rtl/clause_terminal.sv
// Terminal cell of one clause row: classifies the clause (sat/unit/conflict/open)
// from the lit-cell outputs, drives the one-cycle implication and the conflict-clause drive.
module clause_terminal #(
   parameter int NUM_LIT   = 8,
   parameter int WIDTH_LVL = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [1:0]                   freelitcnt_i,
   input  logic [2*NUM_LIT-1:0]         lit_i,
   input  logic [NUM_LIT-1:0]           clausesat_i,
   input  logic [NUM_LIT*WIDTH_LVL-1:0] lit_max_lvl_i,
   input  logic [NUM_LIT-1:0]           cclause_i,
   input  logic                         wr_i,
   input  logic                         bcp_start_i,
   input  logic                         apply_bkt_i,
   input  logic                         analyze_i,
   output logic                         imp_drv_o,
   output logic                         cclause_drv_o,
   output logic [WIDTH_LVL-1:0]         max_lvl_o,
   output logic                         imp_valid_o,
   output logic                         sat_o,
   output logic                         conflict_o,
   output logic                         reason_o,
   output logic                         done_o
);

   typedef enum logic [1:0] {IDLE, EVAL, IMPLY, HOLD} state_t;

   state_t               state_reg;
   logic [WIDTH_LVL-1:0] max_lvl_reg;
   logic [WIDTH_LVL-1:0] lvl_arr [NUM_LIT];
   logic [WIDTH_LVL-1:0] lvl_c;
   logic                 part;
   logic                 sat_c;
   logic                 any_cclause;
   logic                 clear;

   generate
      for (genvar gi = 0; gi < NUM_LIT; gi++) begin : g_lvl
         assign lvl_arr[gi] = lit_max_lvl_i[gi*WIDTH_LVL +: WIDTH_LVL];
      end
   endgenerate

   always_comb begin
      lvl_c = '0;
      for (int k = 0; k < NUM_LIT; k++) begin
         if (lvl_arr[k] > lvl_c) lvl_c = lvl_arr[k];
      end
   end

   assign part        = |lit_i;
   assign sat_c       = |clausesat_i;
   assign any_cclause = |cclause_i;
   assign clear       = wr_i | apply_bkt_i;
   assign max_lvl_o   = max_lvl_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         max_lvl_reg   <= '0;
         imp_drv_o     <= 1'b0;
         imp_valid_o   <= 1'b0;
         sat_o         <= 1'b0;
         conflict_o    <= 1'b0;
         done_o        <= 1'b0;
         reason_o      <= 1'b0;
         cclause_drv_o <= 1'b0;
      end else begin
         cclause_drv_o <= analyze_i & conflict_o;
         reason_o      <= analyze_i & any_cclause & ~clear;
         // The implication pulse is one cycle by construction: only EVAL->IMPLY sets it.
         imp_drv_o     <= 1'b0;
         imp_valid_o   <= 1'b0;
         if (clear) begin
            state_reg   <= IDLE;
            sat_o       <= 1'b0;
            conflict_o  <= 1'b0;
            done_o      <= 1'b0;
            max_lvl_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (bcp_start_i) state_reg <= EVAL;
               end
               EVAL: begin
                  if (!part) begin
                     state_reg <= HOLD;
                     done_o    <= 1'b1;
                  end else if (sat_c) begin
                     sat_o     <= 1'b1;
                     state_reg <= HOLD;
                     done_o    <= 1'b1;
                  end else if (freelitcnt_i == 2'b00) begin
                     conflict_o <= 1'b1;
                     state_reg  <= HOLD;
                     done_o     <= 1'b1;
                  end else if (freelitcnt_i == 2'b01) begin
                     max_lvl_reg <= lvl_c;
                     imp_drv_o   <= 1'b1;
                     imp_valid_o <= 1'b1;
                     state_reg   <= IMPLY;
                  end else begin
                     state_reg <= HOLD;
                     done_o    <= 1'b1;
                  end
               end
               IMPLY: begin
                  state_reg <= HOLD;
                  done_o    <= 1'b1;
               end
               HOLD: begin
                  if (bcp_start_i) begin
                     state_reg  <= EVAL;
                     sat_o      <= 1'b0;
                     conflict_o <= 1'b0;
                     done_o     <= 1'b0;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule
